// File: rtl/countdown_pkg.sv
// Shared types and digit moduli for the countdown timer slice.
package countdown_pkg;

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

   typedef logic [3:0] bcd_t;

   localparam int unsigned TENTH_MOD    = 10;
   localparam int unsigned SEC_ONES_MOD = 10;
   localparam int unsigned SEC_TENS_MOD = 6;
   localparam int unsigned MIN_MOD      = 10;

   function automatic bcd_t clamp_bcd(input bcd_t d, input bcd_t max_val);
      return (d > max_val) ? max_val : d;
   endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD down-counting digit; chained through borrow to form M:SS.t.
module bcd_digit_down
   import countdown_pkg::*;
#(
   parameter int unsigned MODULUS = 10
) (
   input  bcd_t digit,
   input  bcd_t load_val,
   input  logic load_en,
   input  logic borrow_in,
   output bcd_t digit_next,
   output logic borrow_out,
   output logic is_zero
);

   localparam bcd_t TOP = bcd_t'(MODULUS - 1);

   always_comb begin
      digit_next = digit;
      borrow_out = 1'b0;
      if (load_en) begin
         digit_next = load_val;
      end else if (borrow_in) begin
         if (digit == '0) begin
            digit_next = TOP;
            borrow_out = 1'b1;
         end else begin
            digit_next = digit - 4'd1;
         end
      end
   end

   assign is_zero = (digit == '0);

endmodule

// File: rtl/countdown_timer.sv
// M:SS.t countdown timer: FSM, 0.1 s prescaler, preset clamp and registered digits.
module countdown_timer
   import countdown_pkg::*;
#(
   parameter int unsigned TICK_CYCLES = 10_000_000
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       load_i,
   input  logic       start_i,
   input  logic [3:0] preset_min_i,
   input  logic [7:0] preset_sec_i,
   input  logic [3:0] preset_tenth_i,
   output logic [3:0] tenth_o,
   output logic [3:0] sec_ones_o,
   output logic [3:0] sec_tens_o,
   output logic [3:0] min_o,
   output logic       running_o,
   output logic       done_o,
   output logic       alarm_o
);

   localparam int unsigned   PW         = $clog2(TICK_CYCLES);
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);

   state_t        state, state_next;
   logic [PW-1:0] presc, presc_next;
   logic          load_q, start_q;
   bcd_t          pre_min_q, pre_tens_q, pre_ones_q, pre_tenth_q;

   logic tick, do_load, at_zero, next_zero, done_next;
   bcd_t tenth_n, ones_n, tens_n, min_n;
   logic b_tenth, b_ones, b_tens, b_min;
   logic z_tenth, z_ones, z_tens, z_min;

   assign tick      = (state == RUN) && (presc == PRESC_LAST);
   assign do_load   = load_q && (state != RUN);
   assign at_zero   = z_tenth & z_ones & z_tens & z_min;
   assign next_zero = (tenth_n == '0) && (ones_n == '0) && (tens_n == '0) && (min_n == '0);

   bcd_digit_down #(.MODULUS(TENTH_MOD)) u_tenth (
      .digit(tenth_o), .load_val(pre_tenth_q), .load_en(do_load), .borrow_in(tick),
      .digit_next(tenth_n), .borrow_out(b_tenth), .is_zero(z_tenth)
   );
   bcd_digit_down #(.MODULUS(SEC_ONES_MOD)) u_sec_ones (
      .digit(sec_ones_o), .load_val(pre_ones_q), .load_en(do_load), .borrow_in(b_tenth),
      .digit_next(ones_n), .borrow_out(b_ones), .is_zero(z_ones)
   );
   bcd_digit_down #(.MODULUS(SEC_TENS_MOD)) u_sec_tens (
      .digit(sec_tens_o), .load_val(pre_tens_q), .load_en(do_load), .borrow_in(b_ones),
      .digit_next(tens_n), .borrow_out(b_tens), .is_zero(z_tens)
   );
   bcd_digit_down #(.MODULUS(MIN_MOD)) u_min (
      .digit(min_o), .load_val(pre_min_q), .load_en(do_load), .borrow_in(b_tens),
      .digit_next(min_n), .borrow_out(b_min), .is_zero(z_min)
   );

   always_comb begin
      state_next = state;
      presc_next = presc;
      done_next  = 1'b0;
      case (state)
         IDLE: begin
            if (do_load) begin
               presc_next = '0;
            end else if (start_q && !at_zero) begin
               state_next = RUN;
               presc_next = '0;
            end
         end
         RUN: begin
            presc_next = tick ? '0 : presc + 1'b1;
            // Expiry outranks a pause landing on the same tick.
            if (tick && next_zero) begin
               state_next = EXPIRED;
               done_next  = 1'b1;
            end else if (start_q) begin
               state_next = PAUSE;
            end
         end
         PAUSE: begin
            if (do_load) begin
               state_next = IDLE;
               presc_next = '0;
            end else if (start_q) begin
               state_next = RUN;
            end
         end
         EXPIRED: begin
            if (do_load) begin
               state_next = IDLE;
               presc_next = '0;
            end else if (start_q) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Button pulses and preset are registered once; the FSM acts on the following edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= IDLE;
         presc       <= '0;
         load_q      <= 1'b0;
         start_q     <= 1'b0;
         pre_min_q   <= '0;
         pre_tens_q  <= '0;
         pre_ones_q  <= '0;
         pre_tenth_q <= '0;
         tenth_o     <= '0;
         sec_ones_o  <= '0;
         sec_tens_o  <= '0;
         min_o       <= '0;
         running_o   <= 1'b0;
         done_o      <= 1'b0;
         alarm_o     <= 1'b0;
      end else begin
         state       <= state_next;
         presc       <= presc_next;
         load_q      <= load_i;
         start_q     <= start_i;
         pre_min_q   <= clamp_bcd(preset_min_i, bcd_t'(MIN_MOD - 1));
         pre_tens_q  <= clamp_bcd(preset_sec_i[7:4], bcd_t'(SEC_TENS_MOD - 1));
         pre_ones_q  <= clamp_bcd(preset_sec_i[3:0], bcd_t'(SEC_ONES_MOD - 1));
         pre_tenth_q <= clamp_bcd(preset_tenth_i, bcd_t'(TENTH_MOD - 1));
         // A borrow out of the minutes digit would wrap to 9:59.9; hold at the floor instead.
         if (!b_min) begin
            tenth_o    <= tenth_n;
            sec_ones_o <= ones_n;
            sec_tens_o <= tens_n;
            min_o      <= min_n;
         end
         running_o <= (state_next == RUN);
         done_o    <= done_next;
         alarm_o   <= (state_next == EXPIRED);
      end
   end

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios plus random pulses against a tenths-count model.
module tb_countdown_timer;

   localparam int TC = 4;
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;

   logic       clk_i = 1'b0;
   logic       rst_i, load_i, start_i;
   logic [3:0] preset_min_i, preset_tenth_i;
   logic [7:0] preset_sec_i;
   logic [3:0] tenth_o, sec_ones_o, sec_tens_o, min_o;
   logic       running_o, done_o, alarm_o;

   int checks   = 0;
   int failures = 0;
   bit live     = 0;

   countdown_timer #(.TICK_CYCLES(TC)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .load_i(load_i), .start_i(start_i),
      .preset_min_i(preset_min_i), .preset_sec_i(preset_sec_i), .preset_tenth_i(preset_tenth_i),
      .tenth_o(tenth_o), .sec_ones_o(sec_ones_o), .sec_tens_o(sec_tens_o), .min_o(min_o),
      .running_o(running_o), .done_o(done_o), .alarm_o(alarm_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: time held as a plain count of tenths.
   typedef struct {
      int mode;
      int t;
      int presc;
      bit done;
      bit ld_q;
      bit st_q;
      int pre;
   } model_t;

   model_t m = '{default: 0};

   function automatic int clamp_tenths(input logic [3:0] mn, input logic [7:0] sc, input logic [3:0] tn);
      int a = (mn > 9) ? 9 : int'(mn);
      int b = (sc[7:4] > 5) ? 5 : int'(sc[7:4]);
      int c = (sc[3:0] > 9) ? 9 : int'(sc[3:0]);
      int d = (tn > 9) ? 9 : int'(tn);
      return a * 600 + b * 100 + c * 10 + d;
   endfunction

   function automatic logic [15:0] to_disp(input int t);
      int s = (t / 10) % 60;
      return {4'(t / 600), 4'(s / 10), 4'(s % 10), 4'(t % 10)};
   endfunction

   function automatic model_t step(input model_t s, input logic rst, input logic ld,
                                   input logic st, input int pre);
      model_t n = s;
      n.done = 0;
      if (rst) begin
         n = '{default: 0};
         return n;
      end
      case (s.mode)
         M_IDLE: begin
            if (s.ld_q) begin
               n.t = s.pre;
               n.presc = 0;
            end else if (s.st_q && s.t != 0) begin
               n.mode = M_RUN;
               n.presc = 0;
            end
         end
         M_RUN: begin
            if (s.presc == TC - 1) begin
               n.presc = 0;
               n.t = s.t - 1;
            end else begin
               n.presc = s.presc + 1;
            end
            if (n.t == 0) begin
               n.mode = M_EXP;
               n.done = 1;
            end else if (s.st_q) begin
               n.mode = M_PAUSE;
            end
         end
         M_PAUSE: begin
            if (s.ld_q) begin
               n.t = s.pre;
               n.presc = 0;
               n.mode = M_IDLE;
            end else if (s.st_q) begin
               n.mode = M_RUN;
            end
         end
         default: begin
            if (s.ld_q) begin
               n.t = s.pre;
               n.presc = 0;
               n.mode = M_IDLE;
            end else if (s.st_q) begin
               n.mode = M_IDLE;
            end
         end
      endcase
      n.ld_q = ld;
      n.st_q = st;
      n.pre  = pre;
      return n;
   endfunction

   always @(posedge clk_i)
      m <= step(m, rst_i, load_i, start_i, clamp_tenths(preset_min_i, preset_sec_i, preset_tenth_i));

   always @(negedge clk_i) begin
      if (live) begin
         chk("model_disp", 32'({min_o, sec_tens_o, sec_ones_o, tenth_o}), 32'(to_disp(m.t)));
         chk("model_flags", 32'({running_o, done_o, alarm_o}),
             32'({m.mode == M_RUN, m.done, m.mode == M_EXP}));
      end
   end

   function automatic logic [31:0] disp();
      return 32'({min_o, sec_tens_o, sec_ones_o, tenth_o});
   endfunction

   function automatic logic [31:0] flags();
      return 32'({running_o, done_o, alarm_o});
   endfunction

   task automatic set_preset(input logic [3:0] mn, input logic [7:0] sc, input logic [3:0] tn);
      preset_min_i   = mn;
      preset_sec_i   = sc;
      preset_tenth_i = tn;
   endtask

   task automatic pulse(input bit ld, input bit st);
      load_i  = ld;
      start_i = st;
      @(negedge clk_i);
      load_i  = 1'b0;
      start_i = 1'b0;
   endtask

   task automatic cycles(input int k);
      repeat (k) @(negedge clk_i);
   endtask

   initial begin
      rst_i = 1'b1;
      load_i = 1'b0;
      start_i = 1'b0;
      set_preset(4'h0, 8'h00, 4'h0);
      cycles(2);
      live = 1;
      chk("reset_disp", disp(), 32'h0);
      chk("reset_flags", flags(), 32'h0);
      rst_i = 1'b0;

      // Borrow chain from 1:00.0
      set_preset(4'h1, 8'h00, 4'h0);
      pulse(1, 0);
      cycles(1);
      chk("load_1000", disp(), 32'h1000);
      pulse(0, 1);
      cycles(1);
      chk("start_running", flags(), 32'b100);
      cycles(3);
      chk("before_first_tick", disp(), 32'h1000);
      cycles(1);
      chk("first_tick", disp(), 32'h0599);
      for (int i = 8; i >= 0; i--) begin
         cycles(4);
         chk("tenth_step", disp(), 32'({12'h059, 4'(i)}));
      end
      cycles(4);
      chk("sec_borrow", disp(), 32'h0589);
      pulse(0, 1);
      cycles(1);
      chk("paused", flags(), 32'b000);

      // Expiry from 0:00.2
      set_preset(4'h0, 8'h00, 4'h2);
      pulse(1, 0);
      cycles(1);
      pulse(0, 1);
      cycles(5);
      chk("exp_first", disp(), 32'h0001);
      cycles(4);
      chk("exp_zero", disp(), 32'h0000);
      chk("exp_done", flags(), 32'b011);
      cycles(1);
      chk("done_one_cycle", flags(), 32'b001);
      cycles(20);
      chk("exp_hold_disp", disp(), 32'h0000);
      chk("exp_hold_alarm", flags(), 32'b001);
      pulse(0, 1);
      chk("ack_pending", flags(), 32'b001);
      cycles(1);
      chk("ack_cleared", flags(), 32'b000);

      // Pause keeps prescaler progress; load ignored in RUN
      set_preset(4'h0, 8'h10, 4'h0);
      pulse(1, 0);
      cycles(1);
      pulse(0, 1);
      cycles(6);
      pulse(0, 1);
      cycles(1);
      chk("pause_flags", flags(), 32'b000);
      chk("pause_disp", disp(), 32'h0099);
      cycles(10);
      chk("pause_hold", disp(), 32'h0099);
      pulse(0, 1);
      cycles(1);
      chk("resume_flags", flags(), 32'b100);
      chk("resume_disp", disp(), 32'h0099);
      cycles(1);
      chk("resume_tick", disp(), 32'h0098);
      set_preset(4'h5, 8'h55, 4'h5);
      pulse(1, 0);
      cycles(2);
      chk("run_load_ignored", disp(), 32'h0098);
      chk("run_load_flags", flags(), 32'b100);
      cycles(1);
      chk("run_after_load_tick", disp(), 32'h0097);
      pulse(0, 1);
      cycles(1);

      // Clamp of out-of-range preset digits
      set_preset(4'hC, 8'h7F, 4'hA);
      pulse(1, 0);
      cycles(1);
      chk("clamp", disp(), 32'h9599);
      chk("clamp_flags", flags(), 32'b000);

      // Start with zero time is ignored
      set_preset(4'h0, 8'h00, 4'h0);
      pulse(1, 0);
      cycles(1);
      pulse(0, 1);
      cycles(2);
      chk("zero_start", flags(), 32'b000);
      chk("zero_disp", disp(), 32'h0000);

      // Load+start together in PAUSE: load wins, prescaler restarts from IDLE
      set_preset(4'h0, 8'h00, 4'h5);
      pulse(1, 0);
      cycles(1);
      pulse(0, 1);
      cycles(3);
      pulse(0, 1);
      cycles(1);
      chk("coll_paused", flags(), 32'b000);
      set_preset(4'h0, 8'h03, 4'h0);
      pulse(1, 1);
      cycles(1);
      chk("coll_load", disp(), 32'h0030);
      chk("coll_idle", flags(), 32'b000);
      pulse(0, 1);
      cycles(4);
      chk("coll_full_period", disp(), 32'h0030);
      cycles(1);
      chk("coll_tick", disp(), 32'h0029);

      // Reset mid-RUN
      rst_i = 1'b1;
      cycles(1);
      chk("rst_run_disp", disp(), 32'h0);
      chk("rst_run_flags", flags(), 32'h0);
      rst_i = 1'b0;

      // Random pulses and presets
      for (int n = 0; n < 2500; n++) begin
         rst_i   = ($urandom_range(0, 299) == 0);
         load_i  = ($urandom_range(0, 19) == 0);
         start_i = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 3) == 0)
            set_preset(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)));
         else
            set_preset(4'h0, {4'h0, 4'($urandom_range(0, 2))}, 4'($urandom_range(0, 15)));
         @(negedge clk_i);
      end
      rst_i = 1'b0;
      load_i = 1'b0;
      start_i = 1'b0;
      cycles(2);
      live = 0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

- Counts down from an operator-loaded M:SS.t time to zero and raises an alarm on expiry.
- Sits beside `stopwatch` in the seven-segment display design. It drives the same four-digit time multiplexer and hex-to-7-segment path.
- Button inputs arrive as single-cycle pulses from the existing debouncers.
- All outputs are registered BCD digits and status flags.

## Interface
- `TICK_CYCLES`, default 10_000_000: clock cycles per 0.1 s decrement; legal range ≥ 2.
- `clk_i  in  1`: system clock; the block's only clock.
- `rst_i  in  1`: reset, synchronous, active-high.
- `load_i  in  1`: single-cycle pulse that latches the preset.
- `start_i  in  1`: single-cycle pulse; toggles start/pause, or acknowledges the alarm.
- `preset_min_i  in  4`: preset minutes, BCD 0–9.
- `preset_sec_i  in  8`: preset seconds, BCD; [7:4] tens 0–5, [3:0] ones 0–9.
- `preset_tenth_i  in  4`: preset tenths, BCD 0–9.
- `tenth_o  out  4`: tenths digit, drives multiplexer in0.
- `sec_ones_o  out  4`: seconds ones digit, drives in1.
- `sec_tens_o  out  4`: seconds tens digit, drives in2.
- `min_o  out  4`: minutes digit, drives in3.
- `running_o  out  1`: high in RUN.
- `done_o  out  1`: one-cycle pulse on entry to EXPIRED.
- `alarm_o  out  1`: high while in EXPIRED.

## Operation
- **States:** IDLE, RUN, PAUSE, EXPIRED.
- **Reset:** state IDLE, all digits 0, prescaler 0; `running_o`, `done_o` and `alarm_o` all 0.
- **`load_i` in IDLE, PAUSE or EXPIRED:**
  - Latches the preset and clamps each digit to its maximum: digits >9 become 9; seconds tens >5 becomes 5.
  - Clears the prescaler and moves to IDLE.
- **`load_i` in RUN:** ignored.
- **`start_i` in IDLE:** moves to RUN if the time is nonzero; otherwise it is ignored.
- **`start_i` in RUN:** moves to PAUSE. **`start_i` in PAUSE:** moves to RUN.
- **`start_i` in EXPIRED:** moves to IDLE. Time stays 0:00.0.
- **Simultaneous `load_i` and `start_i`:**
  - In RUN, start wins and the state becomes PAUSE.
  - In every other state, load wins and start is dropped.
- **Prescaler:**
  - Counts 0..TICK_CYCLES-1 only in RUN.
  - A tick occurs when the count equals TICK_CYCLES-1; the count then wraps to 0.
  - PAUSE holds the prescaler value, so fractional progress is kept on resume.
- **Decrement on tick:** subtract one tenth with BCD borrow chain tenth → sec_ones → sec_tens → min.
  - Moduli are 10, 10, 6 and 10.
  - A borrowing digit reloads to its modulus minus 1.
- **Expiry:** if the decremented result is 0:00.0, move to EXPIRED in the same update. `done_o` pulses for that one cycle.
- **Floor:** the time never goes below 0:00.0 and never wraps to 9:59.9.
- **Width:** the prescaler is `$clog2(TICK_CYCLES)` bits.

## Timing
- Let edge N be the clock edge that samples `start_i` in IDLE. From edge N+1, `running_o`=1 and the prescaler is 0.
- The first decrement is visible after edge N+TICK_CYCLES+1. Each following decrement comes exactly TICK_CYCLES cycles later.
- Load results are visible on the outputs one cycle after the sampling edge.
- `done_o` and `alarm_o` rise after the same edge as the final decrement.
- `done_o` is high for exactly one cycle. `alarm_o` stays high until `start_i` or `load_i` is accepted, or until reset.
- `rst_i` mid-RUN or mid-EXPIRED forces the full reset state after the next edge. `rst_i` has priority over all inputs.

## Structure
- **Shared package `countdown_pkg`:**
  - `state_t` enum {IDLE, RUN, PAUSE, EXPIRED}.
  - `bcd_t` (logic [3:0]).
  - Digit modulus constants: 10, 10, 6, 10.
- **Sub-module `bcd_digit_down`:**
  - Parameter `MODULUS`.
  - Inputs: digit in, load value, load enable, borrow in.
  - Outputs: digit next, borrow out, is_zero.
  - Instantiated four times and chained.
- **Top level:** FSM, prescaler, clamp logic and output registers.

## Test plan
Every scenario uses TICK_CYCLES=4.

- **Reset:** assert `rst_i` for 2 cycles → all digits 0, `running_o`/`done_o`/`alarm_o` 0, state IDLE.
- **Borrow chain:** load 1:00.0, start → first change after 5 edges to 0:59.9; then every 4 cycles 0:59.8 … 0:59.0, 0:58.9.
- **Expiry:** load 0:00.2, start → 0:00.1, then 0:00.0.
  - `done_o` is high for exactly 1 cycle and `alarm_o` stays high.
  - The display stays 0:00.0 for a further 20 cycles.
  - A `start_i` pulse then clears `alarm_o` and the state returns to IDLE.
- **Pause and load priority:**
  - Start with 0:10.0 loaded, pause 2 cycles after a tick, then hold 10 cycles → digits and prescaler unchanged.
  - Resume → next tick arrives 2 cycles after resume.
  - `load_i` pulsed during RUN is ignored.
- **Clamp:** load preset min=0xC, sec=0x7F, tenth=0xA → display 9:59.9.
- **Zero start and collision:**
  - Load 0:00.0, pulse start → stays IDLE and `running_o` stays 0.
  - In PAUSE, pulse `load_i` and `start_i` together → new preset latched, state IDLE.
